// File: rtl/ad_ip_jesd204_tpl_adc_deframer_aligned_pkg.sv
// ad_ip_jesd204_tpl_pkg
// Shared definitions for the JESD204 transport-layer ADC deframer:
//   - lock FSM state encoding
//   - derived-width helpers (samples per beat, frame bits per lane, clog2)
package ad_ip_jesd204_tpl_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } align_state_t;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Sample containers delivered per link beat across all lanes.
    function automatic int samples_per_beat(input int opb, input int lanes, input int np);
        return (8 * opb * lanes) / np;
    endfunction

    // Bits of one frame carried by a single lane.
    function automatic int frame_bits_per_lane(input int m, input int s, input int np,
                                               input int lanes);
        return (m * s * np) / lanes;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_lane_align.sv
// ad_ip_jesd204_tpl_adc_lane_align
// Per-lane octet realignment. Keeps the previous valid beat and selects an
// OCTETS_PER_BEAT wide window out of {current, previous}, starting at octet
// i_offset of the previous beat. Offset 0 returns the previous beat as-is,
// i.e. the lane data delayed by one valid beat.
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_beat_en        valid beat: previous-beat buffer captures i_data
//   i_offset         octet rotation (shared by all lanes)
//   i_data           current lane beat, octet 0 at LSB
//   o_aligned        realigned beat, octet 0 at LSB (combinational)
module ad_ip_jesd204_tpl_adc_lane_align #(
    parameter int OCTETS_PER_BEAT = 8,
    parameter int OFF_W           = 3
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_beat_en,
    input  logic [OFF_W-1:0]             i_offset,
    input  logic [8*OCTETS_PER_BEAT-1:0] i_data,
    output logic [8*OCTETS_PER_BEAT-1:0] o_aligned
);

    localparam int LANE_W = 8 * OCTETS_PER_BEAT;

    logic [LANE_W-1:0]   r_prev;
    logic [2*LANE_W-1:0] w_window;
    logic [2*LANE_W-1:0] w_shifted;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev <= '0;
        end else if (i_beat_en) begin
            r_prev <= i_data;
        end
    end

    // Previous beat in the low half so the window walks forward in time.
    assign w_window  = {i_data, r_prev};
    assign w_shifted = w_window >> {i_offset, 3'b000};
    assign o_aligned = w_shifted[LANE_W-1:0];

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_deframer_aligned.sv
// ad_ip_jesd204_tpl_adc_deframer_aligned
// JESD204 RX transport-layer deframer with frame-alignment tracking.
// Lane octet streams are realigned to the locked SOF octet, deframed into
// per-channel sample containers, split into sample/control bits and extended.
// Two valid-beat pipeline: stage 1 = per-lane previous-beat buffer feeding the
// rotator, stage 2 = deframed/extracted output register. Nothing advances on
// beats with i_link_valid low.
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_link_valid          link beat qualifier
//   i_link_sof            start-of-frame marker per octet slot
//   i_link_data           lane n at [n*8*OPB +: 8*OPB], octet 0 at LSB
//   o_adc_valid           output beat qualifier
//   o_adc_data            samples, channel-major, sample 0 at LSB
//   o_adc_ctrl            control bits per sample, same ordering
//   o_align_locked        frame alignment locked
//   o_align_offset        octet rotation in use
//   o_align_err_count     saturating count of SOF mismatch beats while locked
module ad_ip_jesd204_tpl_adc_deframer_aligned
    import ad_ip_jesd204_tpl_pkg::*;
#(
    parameter int NUM_LANES            = 1,
    parameter int NUM_CHANNELS         = 4,
    parameter int BITS_PER_SAMPLE      = 16,
    parameter int CONVERTER_RESOLUTION = 14,
    parameter int CONTROL_BITS         = 0,
    parameter int SAMPLES_PER_FRAME    = 1,
    parameter int OCTETS_PER_BEAT      = 8,
    parameter int EN_FRAME_ALIGN       = 1,
    parameter int SIGN_EXTEND          = 1,
    parameter int OUT_SAMPLE_WIDTH     = 16,
    parameter int ALIGN_CHECK_BEATS    = 4,
    parameter int ALIGN_ERR_THRESH     = 3,
    parameter int ERR_CNT_WIDTH        = 8
) (
    input  logic                                       i_clk,
    input  logic                                       i_reset,
    input  logic                                       i_link_valid,
    input  logic [OCTETS_PER_BEAT-1:0]                 i_link_sof,
    input  logic [8*OCTETS_PER_BEAT*NUM_LANES-1:0]     i_link_data,
    output logic                                       o_adc_valid,
    output logic [samples_per_beat(OCTETS_PER_BEAT, NUM_LANES, BITS_PER_SAMPLE)
                  *OUT_SAMPLE_WIDTH-1:0]               o_adc_data,
    output logic [samples_per_beat(OCTETS_PER_BEAT, NUM_LANES, BITS_PER_SAMPLE)
                  *((CONTROL_BITS > 0) ? CONTROL_BITS : 1)-1:0] o_adc_ctrl,
    output logic                                       o_align_locked,
    output logic [clog2(OCTETS_PER_BEAT)-1:0]          o_align_offset,
    output logic [ERR_CNT_WIDTH-1:0]                   o_align_err_count
);

    localparam int LANE_W = 8 * OCTETS_PER_BEAT;
    localparam int DATA_W = LANE_W * NUM_LANES;
    localparam int SPB    = samples_per_beat(OCTETS_PER_BEAT, NUM_LANES, BITS_PER_SAMPLE);
    localparam int FBL    = frame_bits_per_lane(NUM_CHANNELS, SAMPLES_PER_FRAME,
                                                BITS_PER_SAMPLE, NUM_LANES);
    localparam int FPB    = LANE_W / FBL;
    localparam int SPC    = SAMPLES_PER_FRAME * FPB;
    localparam int CTRL_W = (CONTROL_BITS > 0) ? CONTROL_BITS : 1;
    localparam int KEEP_W = CONVERTER_RESOLUTION + CONTROL_BITS;
    localparam int OFF_W  = clog2(OCTETS_PER_BEAT);
    localparam int CNT_W  = clog2(ALIGN_CHECK_BEATS + 1);
    localparam int RUN_W  = clog2(ALIGN_ERR_THRESH + 1);
    localparam int FRM_W  = BITS_PER_SAMPLE * SAMPLES_PER_FRAME * NUM_CHANNELS;

    if ((DATA_W % FRM_W) != 0 || (FRM_W % NUM_LANES) != 0) begin : g_err_frame
        $error("beat width is not a whole number of frames");
    end
    if (CONTROL_BITS > BITS_PER_SAMPLE - CONVERTER_RESOLUTION) begin : g_err_ctrl
        $error("CONTROL_BITS does not fit below the sample bits");
    end
    if (OUT_SAMPLE_WIDTH < CONVERTER_RESOLUTION) begin : g_err_out
        $error("OUT_SAMPLE_WIDTH narrower than CONVERTER_RESOLUTION");
    end

    // ---------------------------------------------------------------- lock FSM
    align_state_t        r_state, w_nx_state;
    logic [OFF_W-1:0]    r_cand, w_nx_cand;
    logic [OFF_W-1:0]    r_offset, w_nx_offset;
    logic [CNT_W-1:0]    r_cnt, w_nx_cnt;
    logic [RUN_W-1:0]    r_run, w_nx_run;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt, w_nx_err_cnt;
    logic [OFF_W-1:0]    w_sof_pos;
    logic                w_sof_beat;

    // Lowest marked octet wins when several SOF bits are set.
    always_comb begin
        w_sof_pos = '0;
        for (int i = OCTETS_PER_BEAT - 1; i >= 0; i--) begin
            if (i_link_sof[i]) w_sof_pos = OFF_W'(i);
        end
    end

    assign w_sof_beat = i_link_valid && (|i_link_sof) && (EN_FRAME_ALIGN != 0);

    always_comb begin
        w_nx_state   = r_state;
        w_nx_cand    = r_cand;
        w_nx_offset  = r_offset;
        w_nx_cnt     = r_cnt;
        w_nx_run     = r_run;
        w_nx_err_cnt = r_err_cnt;
        if (w_sof_beat) begin
            case (r_state)
                ST_UNLOCKED: begin
                    w_nx_cand = w_sof_pos;
                    w_nx_cnt  = CNT_W'(1);
                    if (ALIGN_CHECK_BEATS == 1) begin
                        w_nx_state  = ST_LOCKED;
                        w_nx_offset = w_sof_pos;
                        w_nx_run    = '0;
                    end else begin
                        w_nx_state = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_sof_pos == r_cand) begin
                        if (r_cnt == CNT_W'(ALIGN_CHECK_BEATS - 1)) begin
                            w_nx_state  = ST_LOCKED;
                            w_nx_offset = r_cand;
                            w_nx_run    = '0;
                        end else begin
                            w_nx_cnt = r_cnt + 1'b1;
                        end
                    end else begin
                        w_nx_cand = w_sof_pos;
                        w_nx_cnt  = CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (w_sof_pos == r_offset) begin
                        w_nx_run = '0;
                    end else begin
                        if (r_err_cnt != '1) w_nx_err_cnt = r_err_cnt + 1'b1;
                        if (r_run == RUN_W'(ALIGN_ERR_THRESH - 1)) begin
                            w_nx_state = ST_UNLOCKED;
                            w_nx_run   = '0;
                        end else begin
                            w_nx_run = r_run + 1'b1;
                        end
                    end
                end
                default: w_nx_state = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_UNLOCKED;
            r_cand    <= '0;
            r_offset  <= '0;
            r_cnt     <= '0;
            r_run     <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_nx_state;
            r_cand    <= w_nx_cand;
            r_offset  <= w_nx_offset;
            r_cnt     <= w_nx_cnt;
            r_run     <= w_nx_run;
            r_err_cnt <= w_nx_err_cnt;
        end
    end

    assign o_align_locked    = (EN_FRAME_ALIGN != 0) ? (r_state == ST_LOCKED) : 1'b1;
    assign o_align_offset    = r_offset;
    assign o_align_err_count = r_err_cnt;

    // ------------------------------------------------- stage 1: realignment
    logic [OFF_W-1:0]  w_rot_off;
    logic [DATA_W-1:0] w_aligned;

    assign w_rot_off = (EN_FRAME_ALIGN != 0) ? r_offset : '0;

    ad_ip_jesd204_tpl_adc_lane_align #(
        .OCTETS_PER_BEAT (OCTETS_PER_BEAT),
        .OFF_W           (OFF_W)
    ) u_lane [NUM_LANES-1:0] (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_beat_en (i_link_valid),
        .i_offset  (w_rot_off),
        .i_data    (i_link_data),
        .o_aligned (w_aligned)
    );

    // ---------------------------------------- deframe, extract, extend
    logic [SPB-1:0][OUT_SAMPLE_WIDTH-1:0] w_smp_data;
    logic [SPB-1:0][CTRL_W-1:0]           w_smp_ctrl;
    logic                                 w_unused_aligned;

    // Tail bits below the control field are dropped on purpose.
    assign w_unused_aligned = ^w_aligned;

    // Output sample k = (channel m, frame f, sample s). Frame bits are read
    // MSB-first: lanes concatenated in order, octets in time order, bit 7 first.
    for (genvar k = 0; k < SPB; k++) begin : g_smp
        localparam int M_IDX = k / SPC;
        localparam int F_IDX = (k % SPC) / SAMPLES_PER_FRAME;
        localparam int S_IDX = k % SAMPLES_PER_FRAME;

        logic [KEEP_W-1:0]               w_keep;
        logic [CONVERTER_RESOLUTION-1:0] w_smp;
        logic                            w_fill;

        for (genvar b = 0; b < KEEP_W; b++) begin : g_bit
            // b = 0 is the container MSB
            localparam int T    = M_IDX * BITS_PER_SAMPLE * SAMPLES_PER_FRAME
                                + S_IDX * BITS_PER_SAMPLE + b;
            localparam int LANE = T / FBL;
            localparam int U    = F_IDX * FBL + (T % FBL);
            localparam int SRC  = LANE * LANE_W + 8 * (U / 8) + 7 - (U % 8);
            assign w_keep[KEEP_W-1-b] = w_aligned[SRC];
        end

        assign w_smp  = w_keep[KEEP_W-1 -: CONVERTER_RESOLUTION];
        assign w_fill = (SIGN_EXTEND != 0) ? w_smp[CONVERTER_RESOLUTION-1] : 1'b0;

        if (OUT_SAMPLE_WIDTH > CONVERTER_RESOLUTION) begin : g_ext
            assign w_smp_data[k] = {{(OUT_SAMPLE_WIDTH-CONVERTER_RESOLUTION){w_fill}}, w_smp};
        end else begin : g_noext
            assign w_smp_data[k] = w_smp;
        end

        if (CONTROL_BITS > 0) begin : g_ctrl
            assign w_smp_ctrl[k] = w_keep[CTRL_W-1:0];
        end else begin : g_noctrl
            assign w_smp_ctrl[k] = '0;
        end
    end

    // ------------------------------------------------- stage 2: output reg
    logic                                 r_s1_vld;
    logic                                 r_adc_valid;
    logic [SPB-1:0][OUT_SAMPLE_WIDTH-1:0] r_adc_data;
    logic [SPB-1:0][CTRL_W-1:0]           r_adc_ctrl;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_vld    <= 1'b0;
            r_adc_valid <= 1'b0;
            r_adc_data  <= '0;
            r_adc_ctrl  <= '0;
        end else begin
            // Output pulses once per valid beat once stage 1 holds real data.
            r_adc_valid <= i_link_valid & r_s1_vld;
            if (i_link_valid) begin
                r_s1_vld   <= 1'b1;
                r_adc_data <= w_smp_data;
                r_adc_ctrl <= w_smp_ctrl;
            end
        end
    end

    assign o_adc_valid = r_adc_valid;
    assign o_adc_data  = r_adc_data;
    assign o_adc_ctrl  = r_adc_ctrl;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_deframer_aligned.sv
module tb_ad_ip_jesd204_tpl_adc_deframer_aligned;

    logic        clk = 1'b0;
    logic        reset;
    logic        link_valid;
    logic [7:0]  link_sof;
    logic [63:0] link_data;

    logic        adc_valid,  adc_valid2;
    logic [63:0] adc_data,   adc_data2;
    logic [3:0]  adc_ctrl;
    logic [7:0]  adc_ctrl2;
    logic        locked,     locked2;
    logic [2:0]  offset,     offset2;
    logic [7:0]  errc,       errc2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_adc_deframer_aligned dut (
        .i_clk(clk), .i_reset(reset), .i_link_valid(link_valid), .i_link_sof(link_sof),
        .i_link_data(link_data), .o_adc_valid(adc_valid), .o_adc_data(adc_data),
        .o_adc_ctrl(adc_ctrl), .o_align_locked(locked), .o_align_offset(offset),
        .o_align_err_count(errc)
    );

    ad_ip_jesd204_tpl_adc_deframer_aligned #(.CONTROL_BITS(2)) dut_cs (
        .i_clk(clk), .i_reset(reset), .i_link_valid(link_valid), .i_link_sof(link_sof),
        .i_link_data(link_data), .o_adc_valid(adc_valid2), .o_adc_data(adc_data2),
        .o_adc_ctrl(adc_ctrl2), .o_align_locked(locked2), .o_align_offset(offset2),
        .o_align_err_count(errc2)
    );

    // Container of channel m in frame j (mix of positive and negative samples).
    function automatic logic [15:0] cval(input int j, input int m);
        return {4'((m * 5 + j * 3 + 9) & 15), 12'((j * 37 + m * 11) & 12'hfff)};
    endfunction

    // Expected output word for frame j: top 14 bits, sign-extended to 16.
    function automatic logic [63:0] frame_exp(input int j);
        logic [63:0] r;
        logic [15:0] c;
        r = '0;
        for (int m = 0; m < 4; m++) begin
            c = cval(j, m);
            r[16*m +: 16] = {{2{c[15]}}, c[15:2]};
        end
        return r;
    endfunction

    // Beat k of an octet stream carrying frames after p pad octets.
    // Frame octet 2m is the MSB of channel m's container.
    function automatic logic [63:0] beat(input int p, input int k);
        logic [63:0] d;
        logic [15:0] c;
        int s, j, idx;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            s = 8 * k + i;
            if (s >= p) begin
                j   = (s - p) / 8;
                idx = (s - p) % 8;
                c   = cval(j, idx / 2);
                d[8*i +: 8] = (idx % 2 == 0) ? c[15:8] : c[7:0];
            end
        end
        return d;
    endfunction

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] sof, input logic [63:0] d);
        link_valid = v;
        link_sof   = sof;
        link_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 8'h00, 64'h0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b1, 8'h04, 64'h1234_5678_9ABC_DEF0);
        step(1'b1, 8'h04, 64'h0FED_CBA9_8765_4321);
        n_tests++; if (adc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", adc_valid); end
        n_tests++; if (adc_data !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", adc_data); end
        n_tests++; if (adc_ctrl2 !== 8'h0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", adc_ctrl2); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
        n_tests++; if (offset !== 3'd0) begin n_fail++; $display("FAIL reset_offset got %0d want 0", offset); end
        n_tests++; if (errc !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt got %0d want 0", errc); end
        reset = 1'b0;
    endtask

    // No SOF: offset stays 0, output is the input beat two edges later.
    task automatic test_passthrough();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 8'h00, beat(0, k));
            n_tests++;
            if (adc_valid !== (k > 0)) begin
                n_fail++; $display("FAIL pass_valid k=%0d got %b want %b", k, adc_valid, k > 0);
            end
            if (k > 0) begin
                n_tests++;
                if (adc_data !== frame_exp(k - 1)) begin
                    n_fail++; $display("FAIL pass_data k=%0d got %h want %h", k, adc_data, frame_exp(k - 1));
                end
            end
        end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL pass_locked got %b want 0", locked); end
    endtask

    // SOF at octet 2 every beat: lock after the 4th, then aligned frames out.
    task automatic test_lock();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 8'h04, beat(2, k));
            n_tests++;
            if (locked !== (k >= 3)) begin
                n_fail++; $display("FAIL lock_state k=%0d got %b want %b", k, locked, k >= 3);
            end
            n_tests++;
            if (offset !== ((k >= 3) ? 3'd2 : 3'd0)) begin
                n_fail++; $display("FAIL lock_offset k=%0d got %0d", k, offset);
            end
            if (k >= 4) begin
                n_tests++;
                if (adc_valid !== 1'b1 || adc_data !== frame_exp(k - 1)) begin
                    n_fail++; $display("FAIL lock_data k=%0d got %b/%h want 1/%h", k, adc_valid, adc_data, frame_exp(k - 1));
                end
            end
        end
    endtask

    // From lock at 2: three SOF beats at 4 drop lock, four more relock at 4.
    task automatic test_unlock_relock();
        for (int k = 10; k < 13; k++) begin
            step(1'b1, 8'h10, beat(2, k));
            n_tests++;
            if (errc !== 8'(k - 9)) begin n_fail++; $display("FAIL err_count k=%0d got %0d want %0d", k, errc, k - 9); end
            n_tests++;
            if (locked !== (k < 12)) begin n_fail++; $display("FAIL err_locked k=%0d got %b want %b", k, locked, k < 12); end
            n_tests++;
            if (offset !== 3'd2 || adc_data !== frame_exp(k - 1)) begin
                n_fail++; $display("FAIL err_hold k=%0d got off %0d data %h", k, offset, adc_data);
            end
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 8'h10, beat(4, k));
            n_tests++;
            if (locked !== (k >= 3)) begin n_fail++; $display("FAIL relock k=%0d got %b want %b", k, locked, k >= 3); end
            if (k >= 3) begin
                n_tests++;
                if (offset !== 3'd4) begin n_fail++; $display("FAIL relock_offset got %0d want 4", offset); end
            end
            if (k >= 4) begin
                n_tests++;
                if (adc_data !== frame_exp(k - 1)) begin
                    n_fail++; $display("FAIL relock_data k=%0d got %h want %h", k, adc_data, frame_exp(k - 1));
                end
            end
        end
        n_tests++; if (errc !== 8'd3) begin n_fail++; $display("FAIL relock_errcnt got %0d want 3", errc); end
    endtask

    // Valid every other cycle; idle cycles carry junk and SOF that must be ignored.
    task automatic test_gapped();
        int nin, nout;
        logic v;
        nin = 0; nout = 0;
        do_reset();
        for (int cyc = 0; cyc < 18; cyc++) begin
            v = (cyc % 2 == 0);
            if (v) begin
                step(1'b1, 8'h00, beat(0, nin));
                nin++;
            end else begin
                step(1'b0, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D);
            end
            n_tests++;
            if (adc_valid !== (v && nin >= 2)) begin
                n_fail++; $display("FAIL gap_valid cyc=%0d got %b want %b", cyc, adc_valid, v && nin >= 2);
            end
            if (adc_valid === 1'b1) begin
                n_tests++;
                if (adc_data !== frame_exp(nout)) begin
                    n_fail++; $display("FAIL gap_data out=%0d got %h want %h", nout, adc_data, frame_exp(nout));
                end
                nout++;
            end
        end
        // The newest beat waits in stage 1 for the next valid beat.
        n_tests++; if (nout != nin - 1) begin n_fail++; $display("FAIL gap_count got %0d want %0d", nout, nin - 1); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL gap_sof_ignored got %b want 0", locked); end
    endtask

    // Containers A003 5FFE 8001 7FFF on channels 0..3.
    task automatic test_ctrl();
        do_reset();
        step(1'b1, 8'h00, 64'hFF7F_0180_FE5F_03A0);
        step(1'b1, 8'h00, 64'hFF7F_0180_FE5F_03A0);
        n_tests++; if (adc_valid2 !== 1'b1) begin n_fail++; $display("FAIL ctrl_valid got %b want 1", adc_valid2); end
        n_tests++;
        if (adc_data2 !== 64'h1FFF_E000_17FF_E800) begin
            n_fail++; $display("FAIL ctrl_data got %h want 1fffe00017ffe800", adc_data2);
        end
        n_tests++; if (adc_ctrl2 !== 8'hDB) begin n_fail++; $display("FAIL ctrl_bits got %h want db", adc_ctrl2); end
        n_tests++;
        if (adc_data !== 64'h1FFF_E000_17FF_E800) begin
            n_fail++; $display("FAIL noctrl_data got %h want 1fffe00017ffe800", adc_data);
        end
        n_tests++; if (adc_ctrl !== 4'h0) begin n_fail++; $display("FAIL noctrl_bits got %h want 0", adc_ctrl); end
    endtask

    // Reset while locked with an error logged and traffic running.
    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b1, 8'h04, beat(2, k));
        step(1'b1, 8'h10, beat(2, 6));
        n_tests++;
        if (locked !== 1'b1 || errc !== 8'd1) begin
            n_fail++; $display("FAIL mid_pre got lock %b err %0d want 1/1", locked, errc);
        end
        reset = 1'b1;
        step(1'b1, 8'h04, beat(2, 7));
        reset = 1'b0;
        n_tests++;
        if (adc_valid !== 1'b0 || adc_data !== 64'h0 || adc_ctrl2 !== 8'h0) begin
            n_fail++; $display("FAIL mid_out got %b %h %h want 0", adc_valid, adc_data, adc_ctrl2);
        end
        n_tests++;
        if (locked !== 1'b0 || offset !== 3'd0 || errc !== 8'd0) begin
            n_fail++; $display("FAIL mid_align got lock %b off %0d err %0d want 0", locked, offset, errc);
        end
        step(1'b1, 8'h00, beat(0, 0));
        n_tests++; if (adc_valid !== 1'b0) begin n_fail++; $display("FAIL mid_first got %b want 0", adc_valid); end
        step(1'b1, 8'h00, beat(0, 1));
        n_tests++;
        if (adc_valid !== 1'b1 || adc_data !== frame_exp(0)) begin
            n_fail++; $display("FAIL mid_second got %b %h want 1 %h", adc_valid, adc_data, frame_exp(0));
        end
    endtask

    initial begin
        reset      = 1'b1;
        link_valid = 1'b0;
        link_sof   = 8'h00;
        link_data  = 64'h0;
        test_reset();
        test_passthrough();
        test_lock();
        test_unlock_relock();
        test_gapped();
        test_ctrl();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
